// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer:
// op encodings, FSM states and the default watchdog limit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int DEF_TIMEOUT = 40;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    COMMIT,
    ERR
  } state_t;

endpackage

// File: rtl/muldiv_watchdog.sv
// Clearable saturating cycle counter; term is high once the
// count sits at LIMIT-1 and stays there until cleared.
module muldiv_watchdog #(
  parameter int LIMIT = 40
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic en,
  output logic term
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  assign term = (count == LAST);

  always_ff @(posedge clk) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !term) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer that launches the iterative mul/div units and
// commits their results into the architectural HI/LO pair.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             timeout,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  output logic             unit_signed,
  output logic             mul_start,
  output logic             div_start,
  input  logic             mul_done,
  input  logic             div_done,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo
);

  state_t state, state_nx;

  logic [1:0] op_q;
  logic       take;
  logic       is_div;
  logic       zero_req;
  logic       sel_done;
  logic       wd_term;

  assign take     = (state == IDLE) && req;
  assign is_div   = (op == OP_DIV) || (op == OP_DIVU);
  assign zero_req = take && is_div && (B == '0);
  assign sel_done = op_q[1] ? div_done : mul_done;

  muldiv_watchdog #(
    .LIMIT(TIMEOUT)
  ) u_wd (
    .clk  (clk),
    .Reset(Reset),
    .clear(state == LAUNCH),
    .en   (state == WAIT),
    .term (wd_term)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req && !zero_req) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      // a done landing on the watchdog limit still commits
      WAIT: begin
        if (sel_done)     state_nx = COMMIT;
        else if (wd_term) state_nx = ERR;
      end
      COMMIT:  state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = 1'b0;
    timeout   = 1'b0;
    mul_start = 1'b0;
    div_start = 1'b0;
    unique case (1'b1)
      (state == LAUNCH): begin
        mul_start = !op_q[1] && !Reset;
        div_start = op_q[1] && !Reset;
      end
      (state == COMMIT): done    = !Reset;
      (state == ERR):    timeout = !Reset;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      hi          <= '0;
      lo          <= '0;
      unit_a      <= '0;
      unit_b      <= '0;
      unit_signed <= 1'b0;
      op_q        <= OP_MULT;
      div_zero    <= 1'b0;
    end else begin
      div_zero <= zero_req;
      if (take) begin
        unit_a      <= A;
        unit_b      <= B;
        op_q        <= op;
        unit_signed <= (op == OP_MULT) || (op == OP_DIV);
      end
      if (state == WAIT && sel_done) begin
        hi <= op_q[1] ? div_hi : mul_hi;
        lo <= op_q[1] ? div_lo : mul_lo;
      end
    end
  end

endmodule
